// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage.
// Issues one instruction-memory request at a time over req/gnt/rvalid.
// It fills the IF/ID register and parks one response in a skid buffer while ID stalls.
// A flush from the branch unit kills wrong-path data, including a response still in flight.
module ifu_fetch #(
    parameter int                    CPU_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST = 32'h00000013
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [CPU_WIDTH-1:0]  i_pc,
    output logic                  o_pcwen,
    input  logic                  i_flush,
    input  logic                  i_stall,
    output logic                  o_imem_req,
    output logic [CPU_WIDTH-1:0]  o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [INST_WIDTH-1:0] i_imem_rdata,
    output logic                  o_ifid_valid,
    output logic [CPU_WIDTH-1:0]  o_ifid_pc,
    output logic [INST_WIDTH-1:0] o_ifid_inst
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic                  drop_q, drop_d;
    logic [CPU_WIDTH-1:0]  pc_q, pc_d;
    logic [CPU_WIDTH-1:0]  skid_pc_q, skid_pc_d;
    logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic                  ifid_valid_q, ifid_valid_d;
    logic [CPU_WIDTH-1:0]  ifid_pc_q, ifid_pc_d;
    logic [INST_WIDTH-1:0] ifid_inst_q, ifid_inst_d;
    logic                  ifid_free;

    // The request is masked during a flush, so a grant and a flush never pulse pcwen together.
    assign o_imem_req   = (state_q == S_REQ) && !i_flush;
    assign o_imem_addr  = i_pc;
    assign o_pcwen      = (o_imem_req && i_imem_gnt) || i_flush;
    assign ifid_free    = !ifid_valid_q || !i_stall;

    assign o_ifid_valid = ifid_valid_q;
    assign o_ifid_pc    = ifid_pc_q;
    assign o_ifid_inst  = ifid_inst_q;

    // Next-state logic: FSM transitions, IF/ID load/consume, and the flush override applied last.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        pc_d         = pc_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;

        if (ifid_valid_q && !i_stall) begin
            ifid_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (o_imem_req && i_imem_gnt) begin
                    pc_d    = i_pc;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    if (drop_q || i_flush) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (ifid_free) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_inst_d  = i_imem_rdata;
                        state_d      = S_REQ;
                    end else begin
                        skid_pc_d   = pc_q;
                        skid_inst_d = i_imem_rdata;
                        state_d     = S_HOLD;
                    end
                end else if (i_flush) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = skid_pc_q;
                    ifid_inst_d  = skid_inst_q;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush beats stalls and loads. Leaving HOLD drops the skid entry.
        if (i_flush) begin
            ifid_valid_d = 1'b0;
            ifid_inst_d  = NOP_INST;
            if (state_q == S_HOLD) begin
                state_d = S_REQ;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            drop_q       <= 1'b0;
            pc_q         <= '0;
            skid_pc_q    <= '0;
            skid_inst_q  <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= NOP_INST;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            pc_q         <= pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: bench for ifu_fetch.
// It models the branch-unit PC and an instruction memory with configurable gnt/rvalid delays.
// A scoreboard queue holds granted fetches, and each IF/ID load is checked against it.
module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [63:0] i_pc;
    logic        o_pcwen;
    logic        i_flush;
    logic        i_stall;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_ifid_valid;
    logic [63:0] o_ifid_pc;
    logic [31:0] o_ifid_inst;

    ifu_fetch #(.CPU_WIDTH(64), .INST_WIDTH(32), .NOP_INST(32'h00000013)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .o_pcwen(o_pcwen),
        .i_flush(i_flush), .i_stall(i_stall),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_ifid_valid(o_ifid_valid), .o_ifid_pc(o_ifid_pc), .o_ifid_inst(o_ifid_inst)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;

    // Branch-unit and memory model state
    logic [63:0] pc_model;
    logic [63:0] flush_target;
    logic        flush_ctl, stall_ctl;
    int          gnt_wait_cfg, rv_lat_cfg, gnt_cnt, rv_cnt;
    logic        pend, pend_stale;
    logic [63:0] pend_addr;
    logic        held_req;
    logic [63:0] held_addr;
    logic        last_req;
    logic [63:0] last_addr;
    int          nreq, nloads;
    logic [95:0] sbq[$];

    // One clock cycle: drive inputs, check combinational outputs, cross the edge, check IF/ID.
    task automatic step();
        logic        acc, exp_pcwen, pre_valid;
        logic [63:0] acc_addr, pre_pc;
        logic [95:0] e;
        i_flush = flush_ctl;
        i_stall = stall_ctl;
        i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata = '0;
        if (pend && rv_cnt == 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata = pend_addr[31:0] ^ 32'h13;
        end
        #1;
        if (o_imem_req) begin
            vectors++;
            if (o_imem_addr !== i_pc) begin
                miscompares++;
                $display("FAIL imem_addr: got %h want %h", o_imem_addr, i_pc);
            end
            vectors++;
            if (pend && !pend_stale) begin
                miscompares++;
                $display("FAIL outstanding: got req=1 want req=0 while response pending");
            end
            if (held_req) begin
                vectors++;
                if (o_imem_addr !== held_addr) begin
                    miscompares++;
                    $display("FAIL addr_stable: got %h want %h", o_imem_addr, held_addr);
                end
            end
            if (gnt_cnt >= gnt_wait_cfg) i_imem_gnt = 1'b1;
            else gnt_cnt++;
        end
        #1;
        exp_pcwen = (o_imem_req && i_imem_gnt) || i_flush;
        vectors++;
        if (o_pcwen !== exp_pcwen) begin
            miscompares++;
            $display("FAIL pcwen: got %b want %b", o_pcwen, exp_pcwen);
        end
        last_req  = o_imem_req;
        last_addr = o_imem_addr;
        acc       = o_imem_req && i_imem_gnt;
        acc_addr  = i_pc;
        held_req  = o_imem_req && !i_imem_gnt;
        held_addr = i_pc;
        pre_valid = o_ifid_valid;
        pre_pc    = o_ifid_pc;
        @(posedge i_clk);
        #1;
        if (i_imem_rvalid) begin
            pend = 1'b0;
            pend_stale = 1'b0;
        end else if (pend && rv_cnt > 0) begin
            rv_cnt--;
        end
        if (i_flush) sbq.delete();
        if (acc) begin
            pend = 1'b1;
            pend_addr = acc_addr;
            rv_cnt = rv_lat_cfg - 1;
            gnt_cnt = 0;
            nreq++;
            sbq.push_back({acc_addr, acc_addr[31:0] ^ 32'h13});
        end
        if (exp_pcwen) pc_model = i_flush ? flush_target : pc_model + 64'd4;
        i_pc = pc_model;
        if (i_flush) begin
            vectors++;
            if (o_ifid_valid !== 1'b0 || o_ifid_inst !== NOP) begin
                miscompares++;
                $display("FAIL flush_ifid: got v=%b inst=%h want v=0 inst=%h", o_ifid_valid, o_ifid_inst, NOP);
            end
        end else if (pre_valid && i_stall) begin
            vectors++;
            if (o_ifid_valid !== 1'b1 || o_ifid_pc !== pre_pc) begin
                miscompares++;
                $display("FAIL stall_hold: got v=%b pc=%h want v=1 pc=%h", o_ifid_valid, o_ifid_pc, pre_pc);
            end
        end else if (o_ifid_valid === 1'b1) begin
            vectors++;
            nloads++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL ifid_load: got pc=%h inst=%h want no load", o_ifid_pc, o_ifid_inst);
            end else begin
                e = sbq.pop_front();
                if (o_ifid_pc !== e[95:32] || o_ifid_inst !== e[31:0]) begin
                    miscompares++;
                    $display("FAIL ifid_load: got pc=%h inst=%h want pc=%h inst=%h",
                             o_ifid_pc, o_ifid_inst, e[95:32], e[31:0]);
                end
            end
        end
    endtask

    // Reset with immediate (asynchronous) output checks; optionally keep a response in flight.
    task automatic do_reset(input logic keep_pend);
        flush_ctl = 1'b0;
        stall_ctl = 1'b0;
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0;
        i_rst = 1'b1;
        #1;
        vectors++;
        if (o_ifid_valid !== 1'b0 || o_ifid_pc !== 64'd0 || o_ifid_inst !== NOP ||
            o_imem_req !== 1'b0 || o_pcwen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b pc=%h inst=%h req=%b pcwen=%b want 0 0 %h 0 0",
                     o_ifid_valid, o_ifid_pc, o_ifid_inst, o_imem_req, o_pcwen, NOP);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        sbq.delete();
        gnt_cnt = 0;
        held_req = 1'b0;
        if (!keep_pend) begin
            pend = 1'b0;
            pend_stale = 1'b0;
        end else begin
            pend_stale = pend;
        end
    endtask

    task automatic set_pc(input logic [63:0] pc);
        pc_model = pc;
        i_pc = pc;
    endtask

    // Run until the next IF/ID load, bounded.
    task automatic run_to_load(input string name, input int budget);
        int start;
        start = nloads;
        for (int i = 0; i < budget && nloads == start; i++) step();
        vectors++;
        if (nloads == start) begin
            miscompares++;
            $display("FAIL %s_timeout: got no IF/ID load within %0d cycles want a load", name, budget);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        set_pc(64'h8000_0000);
    endtask

    task automatic test_zero_wait();
        int r0, l0;
        do_reset(1'b0);
        set_pc(64'h8000_0000);
        gnt_wait_cfg = 0;
        rv_lat_cfg = 1;
        r0 = nreq;
        l0 = nloads;
        for (int i = 0; i < 7; i++) step();
        vectors++;
        if (nreq - r0 != 3 || nloads - l0 != 3) begin
            miscompares++;
            $display("FAIL zero_wait_rate: got req=%0d loads=%0d want 3 3", nreq - r0, nloads - l0);
        end
    endtask

    task automatic test_gnt_delay();
        int r0;
        do_reset(1'b0);
        set_pc(64'h8000_0000);
        gnt_wait_cfg = 3;
        rv_lat_cfg = 1;
        step();
        r0 = nreq;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (nreq != r0 || last_req !== 1'b1 || last_addr !== 64'h8000_0000) begin
            miscompares++;
            $display("FAIL gnt_delay_hold: got grants=%0d req=%b addr=%h want 0 1 80000000",
                     nreq - r0, last_req, last_addr);
        end
        step();
        vectors++;
        if (nreq != r0 + 1) begin
            miscompares++;
            $display("FAIL gnt_delay_grant: got grants=%0d want 1", nreq - r0);
        end
        run_to_load("gnt_delay", 10);
    endtask

    task automatic test_stall_skid();
        int r0;
        do_reset(1'b0);
        set_pc(64'h8000_0000);
        gnt_wait_cfg = 0;
        rv_lat_cfg = 1;
        run_to_load("stall_first", 10);
        stall_ctl = 1'b1;
        r0 = nreq;
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (nreq - r0 != 1 || last_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_noreq: got grants=%0d req=%b want 1 0", nreq - r0, last_req);
        end
        stall_ctl = 1'b0;
        step();
        vectors++;
        if (o_ifid_valid !== 1'b1 || o_ifid_pc !== 64'h8000_0004) begin
            miscompares++;
            $display("FAIL skid_release: got v=%b pc=%h want 1 80000004", o_ifid_valid, o_ifid_pc);
        end
        step();
        vectors++;
        if (last_req !== 1'b1 || last_addr !== 64'h8000_0008) begin
            miscompares++;
            $display("FAIL resume_addr: got req=%b addr=%h want 1 80000008", last_req, last_addr);
        end
    endtask

    task automatic test_flush_wait();
        do_reset(1'b0);
        set_pc(64'h8000_0000);
        gnt_wait_cfg = 0;
        rv_lat_cfg = 3;
        step();
        step();
        flush_target = 64'h8000_0100;
        flush_ctl = 1'b1;
        step();
        flush_ctl = 1'b0;
        step();
        step();
        vectors++;
        if (o_ifid_valid !== 1'b0 || o_ifid_inst !== NOP || pend !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop: got v=%b inst=%h want v=0 inst=%h", o_ifid_valid, o_ifid_inst, NOP);
        end
        step();
        vectors++;
        if (last_req !== 1'b1 || last_addr !== 64'h8000_0100) begin
            miscompares++;
            $display("FAIL flush_target: got req=%b addr=%h want 1 80000100", last_req, last_addr);
        end
        run_to_load("flush_wait", 10);
    endtask

    task automatic test_flush_stall_hold();
        do_reset(1'b0);
        set_pc(64'h8000_0000);
        gnt_wait_cfg = 0;
        rv_lat_cfg = 1;
        run_to_load("hold_first", 10);
        stall_ctl = 1'b1;
        for (int i = 0; i < 3; i++) step();
        flush_target = 64'h8000_0200;
        flush_ctl = 1'b1;
        step();
        flush_ctl = 1'b0;
        stall_ctl = 1'b0;
        step();
        vectors++;
        if (last_req !== 1'b1 || last_addr !== 64'h8000_0200 || o_ifid_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_flush: got req=%b addr=%h v=%b want 1 80000200 0",
                     last_req, last_addr, o_ifid_valid);
        end
        run_to_load("hold_flush", 10);
    endtask

    task automatic test_reset_in_wait();
        do_reset(1'b0);
        set_pc(64'h8000_0000);
        gnt_wait_cfg = 0;
        rv_lat_cfg = 4;
        step();
        step();
        step();
        do_reset(1'b1);
        gnt_wait_cfg = 4;
        step();
        step();
        vectors++;
        if (last_req !== 1'b1 || last_addr !== 64'h8000_0004) begin
            miscompares++;
            $display("FAIL restart_addr: got req=%b addr=%h want 1 80000004", last_req, last_addr);
        end
        step();
        vectors++;
        if (o_ifid_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL late_rvalid: got v=%b want 0", o_ifid_valid);
        end
        run_to_load("reset_wait", 15);
    endtask

    initial begin
        i_rst = 1'b0;
        i_pc = '0;
        pc_model = '0;
        flush_target = '0;
        flush_ctl = 1'b0;
        stall_ctl = 1'b0;
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata = '0;
        gnt_wait_cfg = 0;
        rv_lat_cfg = 1;
        gnt_cnt = 0;
        rv_cnt = 0;
        pend = 1'b0;
        pend_stale = 1'b0;
        pend_addr = '0;
        held_req = 1'b0;
        held_addr = '0;
        last_req = 1'b0;
        last_addr = '0;
        nreq = 0;
        nloads = 0;
        @(posedge i_clk);
        #1;
        test_reset();
        test_zero_wait();
        test_gnt_delay();
        test_stall_skid();
        test_flush_wait();
        test_flush_stall_hold();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
